// File: rtl/tmng_pkg.sv
// Shared types and constants for the NAND-core pin sequencer.
// Op words are 21 bits: {src_a, src_b, dst}, each a 7-bit core register address.
package tmng_pkg;

  localparam int TMNG_ADDR_W = 7;
  localparam logic [TMNG_ADDR_W-1:0] TMNG_ZERO_ADDR = 7'd0;
  localparam logic [TMNG_ADDR_W-1:0] TMNG_ONE_ADDR  = 7'd1;

  typedef struct packed {
    logic [TMNG_ADDR_W-1:0] src_a;
    logic [TMNG_ADDR_W-1:0] src_b;
    logic [TMNG_ADDR_W-1:0] dst;
  } tmng_op_t;

  localparam int TMNG_OP_W = $bits(tmng_op_t);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD_A,
    S_EVAL,
    S_COMMIT,
    S_RELEASE,
    S_DONE
  } seq_state_t;

  // One core pin byte: bit 7 is the strobe (mode or commit), bits 6:0 an address.
  function automatic logic [7:0] pin_word(input logic hi, input logic [TMNG_ADDR_W-1:0] addr);
    return {hi, addr};
  endfunction

endpackage

// File: rtl/tmng_prog_mem.sv
// Program store: DEPTH x op RAM, one write port, registered read port (1-cycle latency).
// No backpressure; read data holds its last value while re is low. Contents are not reset.
module tmng_prog_mem
  import tmng_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  tmng_op_t      wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output tmng_op_t      rdata
);

  tmng_op_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/tmng_sequencer.sv
// Replays a stored NAND-op program onto the core pins; 1+2*SETTLE+1+COMMIT_LO cycles per op.
// start and prog_we are dropped while a run is in progress (and start in the DONE cycle).
module tmng_sequencer
  import tmng_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int AW        = $clog2(DEPTH),
  parameter int SETTLE    = 4,
  parameter int COMMIT_LO = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 prog_we,
  input  logic [AW-1:0]        prog_addr,
  input  logic [TMNG_OP_W-1:0] prog_data,
  input  logic [AW:0]          prog_len,
  input  logic                 start,
  input  logic                 wb_i,
  output logic [7:0]           ui_drv,
  output logic [7:0]           uio_drv,
  output logic                 busy,
  output logic                 done,
  output logic                 last_wb
);

  localparam int CNT_MAX = (SETTLE > COMMIT_LO) ? SETTLE : COMMIT_LO;
  localparam int CNT_W   = $clog2(CNT_MAX);

  seq_state_t       state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic [AW-1:0]    pc_q;
  logic [AW:0]      len_q;
  tmng_op_t         op;
  logic             settle_end, lo_end, last_op;

  assign settle_end = (cnt_q == CNT_W'(SETTLE - 1));
  assign lo_end     = (cnt_q == CNT_W'(COMMIT_LO - 1));
  // pc is only AW bits so a full-depth run wraps it to 0; compare one ahead in AW+1 bits.
  assign last_op    = (({1'b0, pc_q} + (AW+1)'(1)) == len_q);

  tmng_prog_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_prog_mem (
    .clk   (clk),
    .we    (prog_we && !busy),
    .waddr (prog_addr),
    .wdata (prog_data),
    .re    (state_q == S_FETCH),
    .raddr (pc_q),
    .rdata (op)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_nxt = (prog_len == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH:   state_nxt = S_LOAD_A;
      S_LOAD_A:  if (settle_end) state_nxt = S_EVAL;
      S_EVAL:    if (settle_end) state_nxt = S_COMMIT;
      S_COMMIT:  state_nxt = S_RELEASE;
      S_RELEASE: if (lo_end) state_nxt = last_op ? S_DONE : S_FETCH;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      pc_q    <= '0;
      len_q   <= '0;
      last_wb <= 1'b0;
    end else begin
      cnt_q <= (state_nxt != state_q) ? '0 : cnt_q + CNT_W'(1);
      if (state_q == S_IDLE && start) begin
        pc_q  <= '0;
        len_q <= prog_len;
      end
      if (state_q == S_RELEASE && lo_end) begin
        pc_q <= pc_q + AW'(1);
      end
      if (state_q == S_EVAL && settle_end) begin
        last_wb <= wb_i;
      end
    end
  end

  // Pins are decoded from state; during FETCH the RAM output still holds the previous op,
  // so re-deriving the RELEASE pattern from it keeps the pins steady between ops.
  always_comb begin
    ui_drv  = '0;
    uio_drv = '0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_FETCH: begin
        busy = 1'b1;
        if (pc_q != '0) begin
          ui_drv  = pin_word(1'b1, op.src_b);
          uio_drv = pin_word(1'b0, op.dst);
        end
      end
      S_LOAD_A: begin
        busy    = 1'b1;
        ui_drv  = pin_word(1'b0, op.src_a);
        uio_drv = pin_word(1'b0, op.dst);
      end
      S_EVAL: begin
        busy    = 1'b1;
        ui_drv  = pin_word(1'b1, op.src_b);
        uio_drv = pin_word(1'b0, op.dst);
      end
      S_COMMIT: begin
        busy    = 1'b1;
        ui_drv  = pin_word(1'b1, op.src_b);
        uio_drv = pin_word(1'b1, op.dst);
      end
      S_RELEASE: begin
        busy    = 1'b1;
        ui_drv  = pin_word(1'b1, op.src_b);
        uio_drv = pin_word(1'b0, op.dst);
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule
